// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : sram_axi_bridge
// Description : Bridges the core's inst/data SRAM-like ports onto one AXI
//               master with single-beat, fully serialised transfers.
//               Optional macro SRAM_AXI_RR_ARB_EN selects round-robin read grant.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_B    = 2'd2
    } wstate_t;

    rstate_t     r_rstate;
    wstate_t     r_wstate;

    logic [3:0]  r_arid;
    logic [31:0] r_araddr;
    logic [2:0]  r_arsize;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_owner_data;

    logic [31:0] r_awaddr;
    logic [2:0]  r_awsize;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;

    logic        w_idle;
    logic        w_inst_wins;
    logic        w_grant_inst;
    logic        w_grant_data;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_unused;

    // Only one transfer in flight across both FSMs, so reads never overtake writes.
    assign w_idle = (r_rstate == R_IDLE) && (r_wstate == W_IDLE) && !reset;

`ifdef SRAM_AXI_RR_ARB_EN
    logic r_last_data;

    // A data write always wins; only read-vs-read contention alternates.
    assign w_inst_wins = inst_sram_req &
                         (!data_sram_req || (!data_sram_wr && r_last_data));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_data <= 1'b0;
        end else if (w_grant_inst) begin
            r_last_data <= 1'b0;
        end else if (w_grant_data && !data_sram_wr) begin
            r_last_data <= 1'b1;
        end
    end
`else
    assign w_inst_wins = inst_sram_req && !data_sram_req;
`endif

    assign w_grant_inst = w_idle && w_inst_wins;
    assign w_grant_data = w_idle && data_sram_req && !w_inst_wins;

    assign inst_sram_addr_ok = w_grant_inst;
    assign data_sram_addr_ok = w_grant_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate     <= R_IDLE;
            r_arid       <= 4'd0;
            r_araddr     <= 32'd0;
            r_arsize     <= 3'd0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_owner_data <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_grant_inst) begin
                        r_arid       <= INST_ID;
                        r_araddr     <= inst_sram_addr;
                        r_arsize     <= {1'b0, inst_sram_size};
                        r_owner_data <= 1'b0;
                        r_arvalid    <= 1'b1;
                        r_rstate     <= R_AR;
                    end else if (w_grant_data && !data_sram_wr) begin
                        r_arid       <= DATA_ID;
                        r_araddr     <= data_sram_addr;
                        r_arsize     <= {1'b0, data_sram_size};
                        r_owner_data <= 1'b1;
                        r_arvalid    <= 1'b1;
                        r_rstate     <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_rstate  <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_rstate <= R_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_rstate  <= R_IDLE;
                end
            endcase
        end
    end

    // A channel counts as done if it already handshook or handshakes this cycle.
    assign w_aw_done = !r_awvalid || awready;
    assign w_w_done  = !r_wvalid  || wready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 32'd0;
            r_awsize  <= 3'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_grant_data && data_sram_wr) begin
                        r_awaddr  <= data_sram_addr;
                        r_awsize  <= {1'b0, data_sram_size};
                        r_wdata   <= data_sram_wdata;
                        r_wstrb   <= data_sram_wstrb;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_wstate  <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_wstate <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_wstate  <= W_IDLE;
                end
            endcase
        end
    end

    assign arid    = r_arid;
    assign araddr  = r_araddr;
    assign arsize  = r_arsize;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;

    assign awid    = DATA_ID;
    assign awaddr  = r_awaddr;
    assign awsize  = r_awsize;
    assign awvalid = r_awvalid;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;
    assign wvalid  = r_wvalid;
    assign wlast   = r_wvalid;
    assign bready  = r_bready;

    // Routing follows the owner recorded at acceptance; rid is deliberately ignored.
    assign inst_sram_data_ok = rvalid && r_rready && !r_owner_data;
    assign data_sram_data_ok = (rvalid && r_rready && r_owner_data) || (bvalid && r_bready);
    assign inst_sram_rdata   = rdata;
    assign data_sram_rdata   = rdata;

    assign w_unused = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid};

endmodule
`default_nettype wire
